// File: rtl/wb_initiator_pkg.sv
// Shared types and constants for the Wishbone classic initiator.
package wb_initiator_pkg;

    // Initiator sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_t;

    // Byte-address increment between consecutive burst beats
    localparam logic [31:0] ADR_STEP = 32'd4;

    // Default number of unacknowledged strobe cycles before abort
    localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/wb_initiator_timer.sv
// Strobe timeout counter for wb_initiator.
// Held at zero while clear is high; counts while enable is high and
// stops once expired, which stays high until the next clear.
module wb_initiator_timer
    import wb_initiator_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count_r;

    // Count strobe cycles; expired flags the last allowed one
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (enable && !expired) begin
            count_r <= count_r + CNT_W'(1);
        end
    end

    assign expired = (count_r == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/wb_initiator.sv
// Wishbone classic initiator: converts a valid/ready command into a single
// or incrementing-burst Wishbone transaction, one response per beat.
// Optional feature macro: WB_INITIATOR_TIMEOUT_EN (strobe timeout abort,
// adds the TIMEOUT parameter). Without it REQ waits for ack indefinitely.
module wb_initiator
    import wb_initiator_pkg::*;
#(
    parameter int LEN_W = 4
`ifdef WB_INITIATOR_TIMEOUT_EN
    ,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic [31:0]      cmd_adr,
    input  logic [3:0]       cmd_sel,
    input  logic [31:0]      cmd_dat,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [3:0]       wbm_sel_o,
    output logic [31:0]      wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    input  logic [31:0]      wbm_dat_i,
    input  logic             wbm_ack_i,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_dat,
    output logic             rsp_err,
    output logic             rsp_last,
    output logic             busy
);

    state_t           state_r;
    logic [LEN_W-1:0] beats_left_r;
    logic             timeout_s;

`ifdef WB_INITIATOR_TIMEOUT_EN
    wb_initiator_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_r != REQ),
        .enable  (state_r == REQ),
        .expired (timeout_s)
    );
`else
    assign timeout_s = 1'b0;
`endif

    // Command/beat sequencer; every bus and response output is a register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            beats_left_r <= {LEN_W{1'b0}};
            cmd_ready    <= 1'b1;
            busy         <= 1'b0;
            wbm_cyc_o    <= 1'b0;
            wbm_stb_o    <= 1'b0;
            wbm_we_o     <= 1'b0;
            wbm_sel_o    <= 4'h0;
            wbm_adr_o    <= 32'h0;
            wbm_dat_o    <= 32'h0;
            rsp_valid    <= 1'b0;
            rsp_dat      <= 32'h0;
            rsp_err      <= 1'b0;
            rsp_last     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        state_r      <= REQ;
                        cmd_ready    <= 1'b0;
                        busy         <= 1'b1;
                        wbm_cyc_o    <= 1'b1;
                        wbm_stb_o    <= 1'b1;
                        wbm_we_o     <= cmd_we;
                        wbm_sel_o    <= cmd_sel;
                        wbm_adr_o    <= cmd_adr;
                        wbm_dat_o    <= cmd_dat;
                        beats_left_r <= cmd_len;
                    end
                end
                REQ: begin
                    // ack wins over a timeout landing in the same cycle
                    if (wbm_ack_i) begin
                        state_r   <= RSP;
                        wbm_stb_o <= 1'b0;
                        wbm_cyc_o <= (beats_left_r != {LEN_W{1'b0}});
                        rsp_valid <= 1'b1;
                        rsp_dat   <= wbm_we_o ? 32'h0 : wbm_dat_i;
                        rsp_err   <= 1'b0;
                        rsp_last  <= (beats_left_r == {LEN_W{1'b0}});
                    end else if (timeout_s) begin
                        // abandon the rest of the command
                        state_r   <= RSP;
                        wbm_stb_o <= 1'b0;
                        wbm_cyc_o <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_dat   <= 32'h0;
                        rsp_err   <= 1'b1;
                        rsp_last  <= 1'b1;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (rsp_last || rsp_err) begin
                            state_r   <= IDLE;
                            cmd_ready <= 1'b1;
                            busy      <= 1'b0;
                            wbm_cyc_o <= 1'b0;
                            rsp_last  <= 1'b0;
                            rsp_err   <= 1'b0;
                        end else begin
                            state_r      <= REQ;
                            wbm_stb_o    <= 1'b1;
                            wbm_adr_o    <= wbm_adr_o + ADR_STEP;
                            beats_left_r <= beats_left_r - LEN_W'(1);
                        end
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    wbm_cyc_o <= 1'b0;
                    wbm_stb_o <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_initiator.sv
// Scoreboard bench for wb_initiator with a counter/memory Wishbone responder.
module tb_wb_initiator;

    localparam int LEN_W = 4;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        err;
        logic        last;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic             cmd_we = 1'b0;
    logic [31:0]      cmd_adr = 32'h0;
    logic [3:0]       cmd_sel = 4'h0;
    logic [31:0]      cmd_dat = 32'h0;
    logic [LEN_W-1:0] cmd_len = '0;
    logic             wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]       wbm_sel_o;
    logic [31:0]      wbm_adr_o, wbm_dat_o;
    logic [31:0]      wbm_dat_i;
    logic             wbm_ack_i;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [31:0]      rsp_dat;
    logic             rsp_err, rsp_last, busy;

    // responder: mode 0 never acks, 1 counter slave, 2 memory (data = adr ^ A5A50000)
    int          resp_mode = 2;
    int          ack_delay = 1;
    int          wait_cnt = 0;
    logic [31:0] ctr_r = 32'h0;
    logic        slv_ack = 1'b0;
    logic        spur_ack = 1'b0;

    int   total = 0;
    int   bad = 0;
    int   cyc_cnt = 0;
    int   last_hs_cnt = -1;
    int   stb_rises = 0;
    int   stb_hi = 0;
    logic stb_prev = 1'b0;

    exp_t        exp_q[$];
    logic [31:0] adr_q[$];

    assign wbm_ack_i = slv_ack | spur_ack;

    always #5 clk = ~clk;

    wb_initiator #(
        .LEN_W (LEN_W)
`ifdef WB_INITIATOR_TIMEOUT_EN
        ,
        .TIMEOUT (8)
`endif
    ) dut (
        .clk (clk), .reset (reset),
        .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_we (cmd_we),
        .cmd_adr (cmd_adr), .cmd_sel (cmd_sel), .cmd_dat (cmd_dat), .cmd_len (cmd_len),
        .wbm_cyc_o (wbm_cyc_o), .wbm_stb_o (wbm_stb_o), .wbm_we_o (wbm_we_o),
        .wbm_sel_o (wbm_sel_o), .wbm_adr_o (wbm_adr_o), .wbm_dat_o (wbm_dat_o),
        .wbm_dat_i (wbm_dat_i), .wbm_ack_i (wbm_ack_i),
        .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_dat (rsp_dat),
        .rsp_err (rsp_err), .rsp_last (rsp_last), .busy (busy)
    );

    // cycle counter
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // registered-ack responder with configurable delay
    always @(posedge clk) begin
        if (reset) begin
            slv_ack  <= 1'b0;
            wait_cnt <= 0;
        end else if (resp_mode != 0 && wbm_cyc_o && wbm_stb_o && !slv_ack) begin
            if (wait_cnt == ack_delay - 1) begin
                slv_ack   <= 1'b1;
                wait_cnt  <= 0;
                wbm_dat_i <= (resp_mode == 1) ? ctr_r : (wbm_adr_o ^ 32'hA5A5_0000);
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end else begin
            slv_ack  <= 1'b0;
            wait_cnt <= 0;
        end
    end

    // free-running counter slave register, loaded by an acknowledged write
    always @(posedge clk) begin
        if (resp_mode == 1 && wbm_cyc_o && wbm_stb_o && wbm_we_o && slv_ack)
            ctr_r <= wbm_dat_o;
        else
            ctr_r <= ctr_r + 32'd1;
    end

    task automatic tally(input bit ok, input string name, input logic [31:0] act,
                         input logic [31:0] req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [31:0] lo, input logic [31:0] hi,
                            input logic err, input logic last);
        exp_t e;
        e.lo = lo; e.hi = hi; e.err = err; e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic present(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                           input logic [31:0] dat, input logic [LEN_W-1:0] len);
        cmd_we = we; cmd_adr = adr; cmd_sel = sel; cmd_dat = dat; cmd_len = len;
        cmd_valid = 1'b1;
    endtask

    // wait for the accepting edge; acc is the cycle count at the preceding negedge
    task automatic wait_accept(input bit drop, output int acc);
        acc = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (cmd_ready) begin
                acc = cyc_cnt;
                break;
            end
        end
        if (acc < 0) tally(1'b0, "accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (drop) cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) tally(1'b0, "idle_timeout", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // monitor: address sequence, strobe statistics and response scoreboard
    initial begin
        exp_t e;
        logic [31:0] ea;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (wbm_stb_o && !stb_prev) begin
                    stb_rises++;
                    if (adr_q.size() > 0) begin
                        ea = adr_q.pop_front();
                        tally(wbm_adr_o == ea, "burst_adr", wbm_adr_o, ea);
                    end
                end
                if (wbm_stb_o) stb_hi++;
                if (rsp_valid && rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        tally(1'b0, "rsp_unexpected", rsp_dat, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        tally(rsp_dat >= e.lo && rsp_dat <= e.hi, "rsp_dat", rsp_dat, e.lo);
                        tally(rsp_err == e.err, "rsp_err", 32'(rsp_err), 32'(e.err));
                        tally(rsp_last == e.last, "rsp_last", 32'(rsp_last), 32'(e.last));
                    end
                    if (rsp_last) last_hs_cnt = cyc_cnt;
                end
            end
            stb_prev = wbm_stb_o;
        end
    end

    initial begin
        int acc, acc_b;
        logic [33:0] snap;
        bit seen;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        tally({wbm_cyc_o, wbm_stb_o, wbm_we_o, rsp_valid, rsp_err, rsp_last, busy, cmd_ready} == 8'b0000_0001,
              "reset_ctrl", 32'({wbm_cyc_o, wbm_stb_o, wbm_we_o, rsp_valid, rsp_err, rsp_last, busy, cmd_ready}), 32'h01);
        tally(wbm_adr_o == 32'h0, "reset_adr", wbm_adr_o, 32'h0);
        tally(wbm_dat_o == 32'h0 && rsp_dat == 32'h0, "reset_dat", wbm_dat_o | rsp_dat, 32'h0);
        tally(wbm_sel_o == 4'h0, "reset_sel", 32'(wbm_sel_o), 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;

        // single write then read on the counter slave
        resp_mode = 1; ack_delay = 1;
        stb_rises = 0;
        push_exp(32'h0, 32'h0, 1'b0, 1'b1);
        present(1'b1, 32'h3000_0000, 4'hF, 32'h0000_1234, 4'd0);
        wait_accept(1'b1, acc);
        wait_idle();
        tally(stb_rises == 1, "single_write_beats", 32'(stb_rises), 32'd1);
        push_exp(32'h0000_1234, 32'h0000_1250, 1'b0, 1'b1);
        present(1'b0, 32'h3000_0000, 4'hF, 32'h0, 4'd0);
        wait_accept(1'b1, acc);
        wait_idle();

        // wrapping read burst, ack delay 2
        resp_mode = 2; ack_delay = 2;
        adr_q.push_back(32'hFFFF_FFF8); adr_q.push_back(32'hFFFF_FFFC);
        adr_q.push_back(32'h0000_0000); adr_q.push_back(32'h0000_0004);
        push_exp(32'h5A5A_FFF8, 32'h5A5A_FFF8, 1'b0, 1'b0);
        push_exp(32'h5A5A_FFFC, 32'h5A5A_FFFC, 1'b0, 1'b0);
        push_exp(32'hA5A5_0000, 32'hA5A5_0000, 1'b0, 1'b0);
        push_exp(32'hA5A5_0004, 32'hA5A5_0004, 1'b0, 1'b1);
        present(1'b0, 32'hFFFF_FFF8, 4'hF, 32'h0, 4'd3);
        wait_accept(1'b1, acc);
        wait_idle();
        tally(adr_q.size() == 0, "burst_adr_count", 32'(adr_q.size()), 32'd0);

        // backpressure on a len=1 read
        ack_delay = 1;
        rsp_ready = 1'b0;
        push_exp(32'hA5A5_0100, 32'hA5A5_0100, 1'b0, 1'b0);
        push_exp(32'hA5A5_0104, 32'hA5A5_0104, 1'b0, 1'b1);
        present(1'b0, 32'h0000_0100, 4'hF, 32'h0, 4'd1);
        wait_accept(1'b1, acc);
        seen = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) tally(1'b0, "bp_rsp_timeout", 32'd0, 32'd1);
        snap = {rsp_dat, rsp_last, rsp_err};
        for (int n = 0; n < 10; n++) begin
            tally(rsp_valid && !wbm_stb_o && ({rsp_dat, rsp_last, rsp_err} == snap),
                  "bp_hold", rsp_dat, snap[33:2]);
            @(negedge clk);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        tally(!wbm_stb_o, "bp_stb_before_hs", 32'(wbm_stb_o), 32'd0);
        @(negedge clk);
        tally(wbm_stb_o && wbm_adr_o == 32'h0000_0104, "bp_restart", wbm_adr_o, 32'h0000_0104);
        wait_idle();

        // spurious ack while idle
        spur_ack = 1'b1;
        @(posedge clk);
        #1 spur_ack = 1'b0;
        repeat (3) @(negedge clk);
        tally(!rsp_valid && !busy, "spurious_ack", 32'({rsp_valid, busy}), 32'd0);
        @(posedge clk);
        #1;

        // command held while busy
        push_exp(32'h0, 32'h0, 1'b0, 1'b1);
        push_exp(32'h0, 32'h0, 1'b0, 1'b1);
        present(1'b1, 32'h0000_0300, 4'h3, 32'hCAFE_0001, 4'd0);
        wait_accept(1'b0, acc);
        present(1'b1, 32'h0000_0304, 4'h3, 32'hCAFE_0002, 4'd0);
        wait_accept(1'b1, acc_b);
        tally(acc_b == last_hs_cnt + 1, "held_cmd_accept", 32'(acc_b), 32'(last_hs_cnt + 1));
        wait_idle();

        // reset during beat 2 of a len=3 write
        push_exp(32'h0, 32'h0, 1'b0, 1'b0);
        present(1'b1, 32'h0000_0200, 4'hF, 32'h0000_0055, 4'd3);
        wait_accept(1'b1, acc);
        seen = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (wbm_stb_o && wbm_adr_o == 32'h0000_0204) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) tally(1'b0, "beat2_timeout", wbm_adr_o, 32'h0000_0204);
        reset = 1'b1;
        @(negedge clk);
        tally({wbm_cyc_o, wbm_stb_o, rsp_valid, busy, cmd_ready} == 5'b00001,
              "reset_midburst", 32'({wbm_cyc_o, wbm_stb_o, rsp_valid, busy, cmd_ready}), 32'h01);
        tally(exp_q.size() == 0, "reset_pending", 32'(exp_q.size()), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // unacknowledged strobe
        resp_mode = 0;
`ifdef WB_INITIATOR_TIMEOUT_EN
        push_exp(32'h0, 32'h0, 1'b1, 1'b1);
        stb_hi = 0;
        present(1'b0, 32'h0000_0400, 4'hF, 32'h0, 4'd2);
        wait_accept(1'b1, acc);
        wait_idle();
        tally(stb_hi == 8, "timeout_stb_cycles", 32'(stb_hi), 32'd8);
        tally(cmd_ready && !wbm_cyc_o, "timeout_idle", 32'({cmd_ready, wbm_cyc_o}), 32'h2);
`else
        present(1'b0, 32'h0000_0400, 4'hF, 32'h0, 4'd2);
        wait_accept(1'b1, acc);
        repeat (40) @(negedge clk);
        tally(wbm_stb_o && wbm_cyc_o && !rsp_valid, "no_timeout_hold",
              32'({wbm_stb_o, wbm_cyc_o, rsp_valid}), 32'h6);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
`endif

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
